// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter collecting button press pulses into an event FIFO; optional drop counter under BTN_EVT_DROP_CNT_EN.
// Latency: press in cycle n appears at the FIFO head (evt_valid/evt_id) in cycle n+2 when uncontended and not full.
// Backpressure: consumer stalls via evt_ready; when full, pending flags hold and repeated presses on them coalesce.
module btn_event_arbiter #(
    parameter int  NUM_BTN = 4,
    parameter int  DEPTH   = 4,
    localparam int ID_W    = $clog2(NUM_BTN),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] pressed,
    input  logic               flush,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic [CW-1:0]      evt_count
`ifdef BTN_EVT_DROP_CNT_EN
    ,
    output logic [7:0]         drop_count
`endif
);

    localparam int            PW        = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_BTN - 1);

    logic [NUM_BTN-1:0] r_pending;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [ID_W-1:0]    r_mem [DEPTH];

    logic               w_found;
    logic               w_grant_vld;
    logic [ID_W-1:0]    w_grant_id;
    logic [NUM_BTN-1:0] w_grant_oh;
    logic               w_pop;
    int                 w_cand;
    logic [ID_W-1:0]    w_idx;

    // Pick the first pending channel at or above rr_ptr (wrapping); grant only while the registered count has room.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_cand     = 0;
        w_idx      = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            w_cand = int'(r_rr_ptr) + k;
            if (w_cand >= NUM_BTN) begin
                w_cand = w_cand - NUM_BTN;
            end
            w_idx = ID_W'(w_cand);
            if (!w_found && r_pending[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
        w_grant_vld = w_found && (r_count != CNT_FULL);
        w_grant_oh  = w_grant_vld ? ({{(NUM_BTN-1){1'b0}}, 1'b1} << w_grant_id) : '0;
        w_pop       = evt_valid && evt_ready;
    end

    // Pending flags, pointers, occupancy; flush clears like reset but keeps the round-robin position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rr_ptr  <= '0;
        end else if (flush) begin
            r_pending <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            // A press on the channel being granted re-arms it as a fresh event.
            r_pending <= (r_pending & ~w_grant_oh) | pressed;
            if (w_grant_vld) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_rr_ptr <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + ID_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_grant_vld, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Event storage; contents need no reset because occupancy gates validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_grant_vld) begin
            r_mem[r_wr_ptr] <= w_grant_id;
        end
    end

    assign evt_valid = (r_count != '0);
    assign evt_id    = r_mem[r_rd_ptr];
    assign evt_count = r_count;

`ifdef BTN_EVT_DROP_CNT_EN
    logic [7:0]         r_drop;
    logic [NUM_BTN-1:0] w_coal;
    logic [8:0]         w_ncoal;
    logic [8:0]         w_drop_sum;

    // Channels pressed again while still pending and not granted lose that press.
    always_comb begin
        w_coal  = pressed & r_pending & ~w_grant_oh;
        w_ncoal = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_ncoal = w_ncoal + 9'(w_coal[i]);
        end
        w_drop_sum = {1'b0, r_drop} + w_ncoal;
    end

    // Saturating count of lost presses.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_drop <= '0;
        end else begin
            r_drop <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
        end
    end

    assign drop_count = r_drop;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
module tb_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pressed;
    logic       flush;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic [2:0] evt_count;
`ifdef BTN_EVT_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];

    btn_event_arbiter #(.NUM_BTN(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pressed   (pressed),
        .flush     (flush),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .evt_count (evt_count)
`ifdef BTN_EVT_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted head event is compared with the oldest expected ID.
    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_unexpected_evt", 1, 0);
            else                   chk("sb_id", {30'd0, evt_id}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] p);
        pressed = p;
        step();
        pressed = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; pressed = '0; evt_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        @(posedge clk);
        #1;
        evt_ready = 1'b1;
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_cnt"}, {29'd0, evt_count}, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pressed = '0; evt_ready = 1'b0;
        step();
        step();
        sample();
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_cnt", {29'd0, evt_count}, 0);
`ifdef BTN_EVT_DROP_CNT_EN
        chk("rst_drop", {24'd0, drop_count}, 0);
`endif
        step();
        rst = 1'b0;

        // Single press: visible two cycles later for exactly one cycle.
        evt_ready = 1'b1;
        exp_q.push_back(1);
        press(4'b0010);
        sample();
        chk("t1_n1_valid", {31'd0, evt_valid}, 0);
        chk("t1_n1_cnt", {29'd0, evt_count}, 0);
        step(); sample();
        chk("t1_n2_valid", {31'd0, evt_valid}, 1);
        chk("t1_n2_id", {30'd0, evt_id}, 1);
        chk("t1_n2_cnt", {29'd0, evt_count}, 1);
        step(); sample();
        chk("t1_n3_valid", {31'd0, evt_valid}, 0);
        chk("t1_n3_cnt", {29'd0, evt_count}, 0);
        step();
        evt_ready = 1'b0;
        chk("t1_q", exp_q.size(), 0);

        // Simultaneous presses from rr_ptr=0 queue as 0,1,3.
        do_reset();
        press(4'b1011);
        step(); step(); step(); sample();
        chk("t2_cnt", {29'd0, evt_count}, 3);
        chk("t2_valid", {31'd0, evt_valid}, 1);
        chk("t2_head", {30'd0, evt_id}, 0);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        drain("t2", 20);

        // Fairness: grant 0 moves rr_ptr to 1, so {0,1,2} is served 1,2,0.
        exp_q.push_back(0);
        press(4'b0001);
        drain("t3a", 20);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        press(4'b0111);
        drain("t3b", 20);

        // Full FIFO: pending[2] holds, second repeat coalesces, refill one cycle after a pop.
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(2);
        press(4'b1111);
        step(); step(); step(); step(); sample();
        chk("t4_full", {29'd0, evt_count}, 4);
        press(4'b0100);
        press(4'b0100);
        step(); step(); sample();
        chk("t4_hold_cnt", {29'd0, evt_count}, 4);
        chk("t4_hold_head", {30'd0, evt_id}, 0);
`ifdef BTN_EVT_DROP_CNT_EN
        chk("t4_drop", {24'd0, drop_count}, 1);
`endif
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        sample();
        chk("t4_pop_cnt", {29'd0, evt_count}, 3);
        step(); sample();
        chk("t4_refill_cnt", {29'd0, evt_count}, 4);
        chk("t4_refill_head", {30'd0, evt_id}, 1);
        drain("t4", 30);

        // Press on a channel in its grant cycle yields a second event, no drop.
        do_reset();
        exp_q.push_back(3); exp_q.push_back(3);
        press(4'b1000);
        press(4'b1000);
        step(); sample();
        chk("t5_cnt", {29'd0, evt_count}, 2);
        step(); sample();
        chk("t5_cnt_stable", {29'd0, evt_count}, 2);
`ifdef BTN_EVT_DROP_CNT_EN
        chk("t5_drop", {24'd0, drop_count}, 0);
`endif
        drain("t5", 20);

        // Flush with count=3, pending=0100: all cleared, press discarded, rr_ptr (3) kept.
        do_reset();
        press(4'b0111);
        step(); step();
        press(4'b0100);
        sample();
        chk("t6_pre_cnt", {29'd0, evt_count}, 3);
        flush = 1'b1; pressed = 4'b0001;
        step();
        flush = 1'b0; pressed = '0;
        sample();
        chk("t6_valid", {31'd0, evt_valid}, 0);
        chk("t6_cnt", {29'd0, evt_count}, 0);
        step(); step(); step(); sample();
        chk("t6_hold_cnt", {29'd0, evt_count}, 0);
        exp_q.push_back(3); exp_q.push_back(0);
        press(4'b1001);
        drain("t6", 20);

        // Reset from the same state: cleared and rr_ptr returns to 0.
        do_reset();
        press(4'b0111);
        step(); step();
        press(4'b0100);
        sample();
        chk("t7_pre_cnt", {29'd0, evt_count}, 3);
        rst = 1'b1; pressed = 4'b0001;
        step();
        rst = 1'b0; pressed = '0;
        sample();
        chk("t7_valid", {31'd0, evt_valid}, 0);
        chk("t7_cnt", {29'd0, evt_count}, 0);
        step(); step(); step(); sample();
        chk("t7_hold_cnt", {29'd0, evt_count}, 0);
        exp_q.push_back(0); exp_q.push_back(3);
        press(4'b1001);
        drain("t7", 20);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Collects single-cycle `pressed` pulses from NUM_BTN debouncer instances.
- Holds one pending flag per button and grants pending buttons round-robin into a small event FIFO.
- Presents the queued button IDs to the consumer (counter/UI logic) over a valid/ready interface.
- Simultaneous presses are never lost unless the same button is pressed again before it has been queued.

Parameters:
- NUM_BTN, 4, number of button channels (2..16)
- DEPTH, 4, event FIFO entries (power of 2, ≥2)
- ID_W, $clog2(NUM_BTN), width of event ID (derived; not overridden)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high, single clock domain
- pressed  input  NUM_BTN  per-button single-cycle press pulses, already synchronized to clk
- flush  input  1  synchronous clear of all pending flags and FIFO contents
- evt_valid  output  1  FIFO head holds an event
- evt_id  output  ID_W  button index of head event; don't-care when evt_valid=0
- evt_ready  input  1  consumer accepts head when evt_valid&&evt_ready
- evt_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at edge): pending=0, FIFO empty, rd/wr pointers=0, rr_ptr=0. evt_valid=0, evt_count=0. rst overrides all other inputs.
- Flush (flush=1, rst=0): same clearing as reset, except rr_ptr is kept. Pulses on `pressed` in that cycle are discarded. Any pop in that cycle is ignored.
- Pending flags: pending[i] set at the edge where pressed[i]=1. pending[i] cleared at the edge where channel i is granted, unless pressed[i]=1 that same cycle; then it stays set, and the new press is a separate event.
- Coalesce: pressed[i]=1 while pending[i]=1 and i is not granted that cycle gives one event. The extra press is lost.
- Grant: combinational from registered pending.
  - At most one grant per cycle, only when evt_count<DEPTH.
  - Registered count is used: a pop in the same cycle does not free a slot for a grant in that cycle.
  - Search starts at rr_ptr and runs upward, wrapping at NUM_BTN-1→0. The first pending index wins.
  - On grant g: write g at wr_ptr, wr_ptr+1 (mod DEPTH), rr_ptr=(g+1) mod NUM_BTN.
- Latency: pressed[i] high in cycle n, FIFO has space, no competing pending → evt_valid=1 with evt_id=i in cycle n+2. evt_count counts it from cycle n+2.
- Pop: evt_valid&&evt_ready at edge → rd_ptr+1 (mod DEPTH). evt_ready while empty has no effect.
- evt_count: +1 on grant only, −1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Full (evt_count==DEPTH): no grant. Pending flags hold indefinitely and further presses on them coalesce. Grants resume the cycle after count drops.
- Empty: evt_valid=0, evt_id holds the last read location value.
- Outputs are registered or derived from registered state only. No combinational path from pressed/evt_ready to evt_valid/evt_id.

Optional Feature:
- Macro BTN_EVT_DROP_CNT_EN.
- Defined: adds output port `drop_count` [7:0].
  - Each edge, it increments by the number of channels coalesced that cycle, saturating at 255.
  - Cleared by rst and by flush.
- Undefined: no port, no counter logic. Behaviour is otherwise identical.

Test Plan:
- Single press: pressed=4'b0010 in cycle 5, evt_ready=1 → evt_valid=1, evt_id=1 in cycle 7 only; evt_count 0→1→0.
- Simultaneous presses, rr_ptr=0: pressed=4'b1011 in one cycle, evt_ready=0 → FIFO holds IDs 0,1,3 in that order; evt_count=3; rr_ptr=0 (after 3).
- Round-robin fairness: after ID 1 is granted, pending={0,2} → next grant is 2, then 0.
- Full FIFO: DEPTH=4, evt_ready=0, presses on all 4 buttons, then button 2 again twice → count=4; pending[2] held. With BTN_EVT_DROP_CNT_EN: second repeat press → drop_count=1. Then evt_ready=1 for one cycle → ID 2 enqueued one cycle later.
- Press during grant: pending[3]=1 and granted while pressed[3]=1 → two events with ID 3 eventually queued, no drop.
- Flush/reset mid-operation: FIFO count=3 and pending=4'b0100 → flush=1 for one cycle → evt_valid=0, evt_count=0, pending=0 next cycle; a press in the flush cycle is ignored. rst=1 gives the same result with rr_ptr=0.
